pixel_word_packer: RTL

// - Stage directly upstream of the parallel LED string drivers: pops 16-bit words from the pixel FIFO.
// - Repacks the words into 24-bit {R,G,B} colour tuples (3 words -> 2 pixels).
// - Presents one pixel at a time on a valid/pop handshake, with start-of-frame marking and per-frame pad-byte removal.
//

---
 rtl/pixel_pkg.sv | 28 ++
 rtl/pixel_byte_accum.sv | 56 +++++
 rtl/pixel_word_packer.sv | 95 +++++++++
 3 files changed

// File: rtl/pixel_pkg.sv
// Shared constants and types for the pixel word packer.
package pixel_pkg;

  localparam int BYTES_PER_PIXEL = 3;
  localparam int BYTES_PER_WORD  = 2;
  localparam int ACC_BYTES       = 4;
  localparam int ACC_CNT_W       = 3;

  // Byte lanes inside a packed {R,G,B} pixel.
  localparam int R_MSB = 23;
  localparam int R_LSB = 16;
  localparam int G_MSB = 15;
  localparam int G_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

  typedef logic [23:0]              pixel_t;
  typedef logic [8*ACC_BYTES-1:0]   acc_t;
  typedef logic [ACC_CNT_W-1:0]     acc_cnt_t;

  // Number of bytes leaving the accumulator for a given take/drop request.
  function automatic acc_cnt_t bytes_removed(input logic take3, input logic drop1);
    acc_cnt_t n;
    n = (take3 ? 3'd3 : 3'd0) + (drop1 ? 3'd1 : 3'd0);
    return n;
  endfunction

endpackage

// File: rtl/pixel_byte_accum.sv
// Four-byte shift accumulator. Byte 0 (oldest) sits in the top lane; unused
// lanes are always zero so a new word can be OR-ed in behind the kept bytes.
module pixel_byte_accum
  import pixel_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_push2,
  input  logic [15:0] i_word,
  input  logic        i_take3,
  input  logic        i_drop1,
  output pixel_t      o_head,
  output acc_cnt_t    o_count
);

  acc_t     r_data;
  acc_cnt_t r_count;

  acc_cnt_t w_removed;
  acc_cnt_t w_kept;
  acc_cnt_t w_next_count;
  acc_t     w_shifted;
  acc_t     w_inserted;
  acc_t     w_next_data;

  // Remove consumed bytes from the head, then append the returning word behind the survivors.
  always_comb begin
    w_removed = bytes_removed(i_take3, i_drop1);
    w_kept    = r_count - w_removed;
    w_shifted = r_data << {w_removed, 3'b000};
    if (i_push2) begin
      w_inserted   = {i_word, 16'h0000} >> {w_kept, 3'b000};
      w_next_count = w_kept + 3'd2;
    end else begin
      w_inserted   = 32'h0000_0000;
      w_next_count = w_kept;
    end
    w_next_data = w_shifted | w_inserted;
  end

  // Accumulator storage; clear has priority over any push in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_data  <= 32'h0000_0000;
      r_count <= 3'd0;
    end else begin
      r_data  <= w_next_data;
      r_count <= w_next_count;
    end
  end

  assign o_head  = r_data[31:8];
  assign o_count = r_count;

endmodule

// File: rtl/pixel_word_packer.sv
// Pops 16-bit words from the pixel FIFO and presents 24-bit RGB pixels on a
// valid/pop handshake, marking pixel 0 of each frame and dropping the frame pad byte.
module pixel_word_packer
  import pixel_pkg::*;
#(
  parameter int PIXELS_PER_FRAME = 600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [15:0] fifo_data,
  input  logic        flush,
  output logic        color_valid,
  output logic [23:0] color_out,
  output logic        color_sof,
  input  logic        color_pop
);

  localparam int              IDX_W      = (PIXELS_PER_FRAME > 1) ? $clog2(PIXELS_PER_FRAME) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PIXELS_PER_FRAME - 1);
  localparam bit              ODD_FRAME  = ((PIXELS_PER_FRAME % 2) != 0);

  // r_inflight marks that fifo_data carries a popped word this cycle. A flush
  // or reset in that data cycle clears the accumulator with priority over the
  // append, so the in-flight word is discarded without a separate flag.
  logic             r_inflight;
  logic             r_color_valid;
  pixel_t           r_color_out;
  logic             r_color_sof;
  logic [IDX_W-1:0] r_pix_idx;

  logic     w_clear;
  logic     w_extract;
  logic     w_last;
  logic     w_drop;
  logic     w_push;
  logic [3:0] w_projected;
  pixel_t   w_acc_head;
  acc_cnt_t w_acc_count;

  pixel_byte_accum u_accum (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_clear),
    .i_push2 (w_push),
    .i_word  (fifo_data),
    .i_take3 (w_extract),
    .i_drop1 (w_drop),
    .o_head  (w_acc_head),
    .o_count (w_acc_count)
  );

  // Extract/read decisions: a read is issued only if the bytes it brings still fit.
  always_comb begin
    w_clear     = reset || flush;
    w_extract   = !w_clear && (w_acc_count >= 3'd3) && (!r_color_valid || color_pop);
    w_last      = (r_pix_idx == LAST_IDX);
    w_drop      = w_extract && w_last && ODD_FRAME;
    w_push      = r_inflight && !w_clear;
    w_projected = {1'b0, w_acc_count} + (r_inflight ? 4'd2 : 4'd0) - (w_extract ? 4'd3 : 4'd0);
    if (!fifo_empty && !w_clear && (w_projected <= 4'd2)) begin
      fifo_rd_en = 1'b1;
    end else begin
      fifo_rd_en = 1'b0;
    end
  end

  // Output register, in-flight tracking and frame pixel index.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_inflight    <= 1'b0;
      r_color_valid <= 1'b0;
      r_color_out   <= 24'h00_0000;
      r_color_sof   <= 1'b0;
      r_pix_idx     <= '0;
    end else begin
      r_inflight <= fifo_rd_en;
      if (w_extract) begin
        r_color_out   <= w_acc_head;
        r_color_valid <= 1'b1;
        r_color_sof   <= (r_pix_idx == '0);
        r_pix_idx     <= w_last ? '0 : (r_pix_idx + IDX_W'(1));
      end else if (color_pop) begin
        r_color_valid <= 1'b0;
        r_color_sof   <= 1'b0;
      end
    end
  end

  assign color_valid = r_color_valid;
  assign color_out   = r_color_out;
  assign color_sof   = r_color_sof;

endmodule
